// File: rtl/capture_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capture_mem_pkg
// Description : Shared constants for the capture-memory bridge: host region
//               select values and status bit positions used when the fill
//               and flag outputs are mapped into a sniffer status register.
// Revision    : 1.0  initial release
// ============================================================================
package capture_mem_pkg;

    // Value of the host region-select address bit for each region
    localparam logic c_REGION_MEM    = 1'b0;
    localparam logic c_REGION_PERIPH = 1'b1;

    // Status word layout: fill count in the low bits, sticky flags on top
    localparam int   c_STAT_FILL_LSB = 0;
    localparam int   c_STAT_WRAP_BIT = 30;
    localparam int   c_STAT_OVF_BIT  = 31;

endpackage
`default_nettype wire

// File: rtl/capture_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : capture_ram_sp
// Description : Single-port 2**ADDR_W x 32 sample RAM with per-byte write
//               enables and a registered read port (1-cycle latency).
//               Written in the read-old-data style that maps onto M9K blocks.
// Revision    : 1.0  initial release
// ============================================================================
module capture_ram_sp #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_be,
    input  logic              i_we,
    output logic [31:0]       o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] r_q;

    // Byte-masked write and registered read of the addressed word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/capture_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : capture_mem_bridge
// Description : Arbitrates one sample RAM between the sniffer capture master
//               (write-only) and the host bridge master. Capture wins by
//               default; a host held off for HOST_STARVE cycles gets the next
//               slot. Host accesses with the region bit set go straight to
//               the peripheral port. Tracks fill level and sticky wrap /
//               overflow status for ring or linear capture.
// Revision    : 1.0  initial release
// ============================================================================
module capture_mem_bridge
    import capture_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int PERIPH_BIT  = 31,
    parameter bit WRAP_EN     = 1'b1,
    parameter int HOST_STARVE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cap_addr_i,
    input  logic [31:0]       cap_data_i,
    input  logic [3:0]        cap_sel_i,
    input  logic              cap_we_i,
    input  logic              cap_stb_i,
    output logic              cap_stall_o,
    output logic              cap_ack_o,
    input  logic [31:0]       host_addr_i,
    input  logic [31:0]       host_data_i,
    output logic [31:0]       host_data_o,
    input  logic [3:0]        host_sel_i,
    input  logic              host_we_i,
    input  logic              host_stb_i,
    input  logic              host_cyc_i,
    output logic              host_stall_o,
    output logic              host_ack_o,
    output logic              periph_stb_o,
    input  logic [31:0]       periph_data_i,
    input  logic              periph_ack_i,
    input  logic              clr_i,
    output logic [ADDR_W:0]   fill_o,
    output logic              wrap_o,
    output logic              overflow_o
);

    localparam int                 c_DEPTH  = 2 ** ADDR_W;
    localparam int                 c_CNT_W  = $clog2(HOST_STARVE + 2);
    localparam logic [ADDR_W:0]    c_FULL   = (ADDR_W+1)'(c_DEPTH);
    localparam logic [c_CNT_W-1:0] c_STARVE = c_CNT_W'(HOST_STARVE);

    logic               r_cap_ack;
    logic               r_host_ack;
    logic               r_sel;
    logic [c_CNT_W-1:0] r_starve;
    logic [ADDR_W:0]    r_fill;
    logic               r_wrap;
    logic               r_ovf;

    logic               w_host_strobe;
    logic               w_hreq;
    logic               w_force;
    logic               w_cap_gnt;
    logic               w_host_gnt;
    logic               w_host_wait;
    logic               w_full;
    logic               w_cap_wr;
    logic               w_cap_commit;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [31:0]        w_ram_wdata;
    logic [3:0]         w_ram_be;
    logic               w_ram_we;
    logic [31:0]        w_ram_q;
    logic               w_unused_addr_bits;

    // Only the word index is decoded; the remaining address bits are don't-care
    assign w_unused_addr_bits = ^{cap_addr_i, host_addr_i};

    assign w_host_strobe = host_cyc_i & host_stb_i;
    assign w_hreq        = w_host_strobe & (host_addr_i[PERIPH_BIT] == c_REGION_MEM);
    assign periph_stb_o  = w_host_strobe & (host_addr_i[PERIPH_BIT] == c_REGION_PERIPH);

    // A host starved for HOST_STARVE cycles steals exactly one slot
    assign w_force      = w_hreq & (r_starve == c_STARVE);
    assign w_cap_gnt    = cap_stb_i & ~w_force;
    assign w_host_gnt   = w_hreq & (~cap_stb_i | w_force);
    assign w_host_wait  = w_hreq & cap_stb_i & ~w_force;

    assign cap_stall_o  = w_force;
    assign host_stall_o = w_host_wait;

    // A full linear buffer drops the write, unless a clear lands in the same cycle
    assign w_full       = (r_fill == c_FULL);
    assign w_cap_wr     = w_cap_gnt & cap_we_i;
    assign w_cap_commit = cap_we_i & (~w_full | WRAP_EN | clr_i);

    assign w_ram_addr  = w_cap_gnt ? cap_addr_i[ADDR_W+1:2] : host_addr_i[ADDR_W+1:2];
    assign w_ram_wdata = w_cap_gnt ? cap_data_i : host_data_i;
    assign w_ram_be    = w_cap_gnt ? cap_sel_i  : host_sel_i;
    assign w_ram_we    = rst_i & (w_cap_gnt ? w_cap_commit : (w_host_gnt & host_we_i));

    capture_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clk_i),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .i_we    (w_ram_we),
        .o_rdata (w_ram_q)
    );

    // Count consecutive cycles the host has been held off by capture
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_starve <= '0;
        end else if (w_host_wait) begin
            r_starve <= r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end

    // Registered acks one cycle after each grant, and host region tracking
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cap_ack  <= 1'b0;
            r_host_ack <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_cap_ack  <= w_cap_gnt;
            r_host_ack <= w_host_gnt;
            if (w_host_strobe) begin
                r_sel <= host_addr_i[PERIPH_BIT];
            end
        end
    end

    // Fill level and sticky status; clear beats counting but keeps the write
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_fill <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr_i) begin
            r_fill <= w_cap_wr ? (ADDR_W+1)'(1) : '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_cap_wr) begin
            if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end else if (WRAP_EN) begin
                r_wrap <= 1'b1;
            end else begin
                r_ovf  <= 1'b1;
            end
        end
    end

    assign cap_ack_o   = r_cap_ack;
    assign host_ack_o  = r_sel ? periph_ack_i  : r_host_ack;
    assign host_data_o = r_sel ? periph_data_i : (r_host_ack ? w_ram_q : 32'h0);
    assign fill_o      = r_fill;
    assign wrap_o      = r_wrap;
    assign overflow_o  = r_ovf;

endmodule
`default_nettype wire
